// File: rtl/exp_in_pkg.sv
// Shared constants for the expansion-connector input block: register offsets and reset defaults.
package exp_in_pkg;

   localparam logic [19:0] OFF_FILT_LEN = 20'h00;
   localparam logic [19:0] OFF_RISE_EN  = 20'h04;
   localparam logic [19:0] OFF_FALL_EN  = 20'h08;
   localparam logic [19:0] OFF_DAT      = 20'h0C;
   localparam logic [19:0] OFF_FLAGS    = 20'h10;
   localparam logic [19:0] OFF_CNT_BASE = 20'h20;

   localparam logic [17:0] CNT_BASE_WORD = OFF_CNT_BASE[19:2];

   localparam int FILT_LEN_RST = 4;

endpackage

// File: rtl/exp_in_filt_bit.sv
// One expansion pin: synchroniser chain, stability filter and edge detect on the filtered level.
module exp_in_filt_bit #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              raw,
   input  logic [FILT_W-1:0] filt_len,
   output logic              filt,
   output logic              rise,
   output logic              fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FILT_W-1:0]      cnt;
   logic                   filt_d;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   // cnt only runs while the synced level disagrees; the >= compare lets a lowered
   // filt_len take effect on a counter that is already past the new length.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt    <= '0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         filt_d <= filt;
         if (sync != filt) begin
            if (cnt >= filt_len) begin
               filt <= sync;
               cnt  <= '0;
            end else begin
               cnt <= cnt + FILT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = filt & ~filt_d;
   assign fall = ~filt & filt_d;

endmodule

// File: rtl/red_pitaya_exp_in.sv
// Expansion-connector input conditioning with its own register window.
// Define EXP_IN_CNT_EN to build the per-pin edge counters at 0x20..0x3C.
module red_pitaya_exp_in
   import exp_in_pkg::*;
#(
   parameter int DWE         = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 8,
   parameter int CNT_W       = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [DWE-1:0] exp_p_raw_i,
   input  logic [DWE-1:0] exp_n_raw_i,
   output logic [DWE-1:0] exp_p_dat_o,
   output logic [DWE-1:0] exp_n_dat_o,
   output logic [DWE-1:0] exp_trig_o,
   input  logic [31:0]    sys_addr,
   input  logic [31:0]    sys_wdata,
   input  logic [3:0]     sys_sel,
   input  logic           sys_wen,
   input  logic           sys_ren,
   output logic [31:0]    sys_rdata,
   output logic           sys_err,
   output logic           sys_ack
);

   logic [19:0]       off;
   logic [DWE-1:0]    p_filt, p_rise, p_fall;
   logic [DWE-1:0]    n_filt, n_rise, n_fall;
   logic [FILT_W-1:0] filt_len;
   logic [DWE-1:0]    rise_en, fall_en;
   logic [DWE-1:0]    flags;
   logic [DWE-1:0]    trig_ev;
   logic [DWE-1:0]    flag_clr;
   logic [31:0]       rd_val;
   logic              unused_bits;

   assign off = sys_addr[19:0];

   for (genvar i = 0; i < DWE; i++) begin : g_pin
      exp_in_filt_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W)
      ) u_p (
         .clk      (clk_i),
         .rst      (rst_i),
         .raw      (exp_p_raw_i[i]),
         .filt_len (filt_len),
         .filt     (p_filt[i]),
         .rise     (p_rise[i]),
         .fall     (p_fall[i])
      );

      exp_in_filt_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W)
      ) u_n (
         .clk      (clk_i),
         .rst      (rst_i),
         .raw      (exp_n_raw_i[i]),
         .filt_len (filt_len),
         .filt     (n_filt[i]),
         .rise     (n_rise[i]),
         .fall     (n_fall[i])
      );
   end

   assign exp_p_dat_o = p_filt;
   assign exp_n_dat_o = n_filt;
   assign sys_err     = 1'b0;

   // N-side edges are produced by the shared pin cell but have no consumer.
   assign unused_bits = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata, n_rise, n_fall};

   assign trig_ev  = (p_rise & rise_en) | (p_fall & fall_en);
   assign flag_clr = (sys_wen && off == OFF_FLAGS) ? sys_wdata[DWE-1:0] : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         filt_len   <= FILT_W'(FILT_LEN_RST);
         rise_en    <= '0;
         fall_en    <= '0;
         flags      <= '0;
         exp_trig_o <= '0;
      end else begin
         if (sys_wen && off == OFF_FILT_LEN) filt_len <= sys_wdata[FILT_W-1:0];
         if (sys_wen && off == OFF_RISE_EN)  rise_en  <= sys_wdata[DWE-1:0];
         if (sys_wen && off == OFF_FALL_EN)  fall_en  <= sys_wdata[DWE-1:0];
         flags      <= (flags & ~flag_clr) | trig_ev;
         exp_trig_o <= trig_ev;
      end
   end

`ifdef EXP_IN_CNT_EN
   localparam int CNT_IW = (DWE > 1) ? $clog2(DWE) : 1;

   logic [CNT_W-1:0]  cnt [DWE];
   logic [17:0]       cnt_word;
   logic [CNT_IW-1:0] cnt_idx;
   logic              cnt_hit;

   assign cnt_word = off[19:2] - CNT_BASE_WORD;
   assign cnt_idx  = cnt_word[CNT_IW-1:0];
   assign cnt_hit  = (off[19:2] >= CNT_BASE_WORD) && (cnt_word < 18'(DWE));

   // A write clears the counter, but an event landing in the same cycle still counts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DWE; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < DWE; i++) begin
            if (sys_wen && cnt_hit && cnt_idx == CNT_IW'(i)) begin
               cnt[i] <= CNT_W'(trig_ev[i]);
            end else if (trig_ev[i]) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

   always_comb begin
      rd_val = '0;
      case (off)
         OFF_FILT_LEN: rd_val = 32'(filt_len);
         OFF_RISE_EN:  rd_val = 32'(rise_en);
         OFF_FALL_EN:  rd_val = 32'(fall_en);
         OFF_DAT:      rd_val = 32'({n_filt, p_filt});
         OFF_FLAGS:    rd_val = 32'(flags);
         default:      rd_val = '0;
      endcase
`ifdef EXP_IN_CNT_EN
      if (cnt_hit) rd_val = 32'(cnt[cnt_idx]);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sys_ack   <= 1'b0;
         sys_rdata <= '0;
      end else begin
         sys_ack   <= sys_wen | sys_ren;
         sys_rdata <= sys_ren ? rd_val : '0;
      end
   end

endmodule

// File: tb/tb_red_pitaya_exp_in.sv
// Bench for red_pitaya_exp_in: register table, directed corner sequences and a randomized run
// compared cycle by cycle against a history-based reference model.
module tb_red_pitaya_exp_in;

   localparam int DWE    = 8;
   localparam int SYNC   = 2;
   localparam int FILT_W = 8;
   localparam int CNT_W  = 4;
   localparam int CMOD   = 1 << CNT_W;
   localparam int MAXC   = 8192;
`ifdef EXP_IN_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic [DWE-1:0] exp_p_raw_i = '0;
   logic [DWE-1:0] exp_n_raw_i = '0;
   logic [DWE-1:0] exp_p_dat_o, exp_n_dat_o, exp_trig_o;
   logic [31:0]    sys_addr = '0;
   logic [31:0]    sys_wdata = '0;
   logic [3:0]     sys_sel = 4'hF;
   logic           sys_wen = 1'b0;
   logic           sys_ren = 1'b0;
   logic [31:0]    sys_rdata;
   logic           sys_err, sys_ack;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   red_pitaya_exp_in #(
      .DWE (DWE), .SYNC_STAGES (SYNC), .FILT_W (FILT_W), .CNT_W (CNT_W)
   ) dut (
      .clk_i (clk), .rst_i (rst_i),
      .exp_p_raw_i (exp_p_raw_i), .exp_n_raw_i (exp_n_raw_i),
      .exp_p_dat_o (exp_p_dat_o), .exp_n_dat_o (exp_n_dat_o), .exp_trig_o (exp_trig_o),
      .sys_addr (sys_addr), .sys_wdata (sys_wdata), .sys_sel (sys_sel),
      .sys_wen (sys_wen), .sys_ren (sys_ren),
      .sys_rdata (sys_rdata), .sys_err (sys_err), .sys_ack (sys_ack)
   );

   // Reference model: hist[t] is the raw {n,p} word sampled at edge t, mf[t] the filtered word after it.
   logic [15:0] hist [0:MAXC];
   logic [15:0] mf   [0:MAXC];
   int          t = 0;
   logic [7:0]  m_len = 8'd4, m_ren = '0, m_fen = '0, m_flags = '0, m_trig = '0;
   int          m_cnt [DWE];
   logic        m_ack = 1'b0;
   logic [31:0] m_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0d)", name, act, req, t);
      end
   endtask

   function automatic logic [15:0] hist_at(input int i);
      return (i <= 0) ? 16'h0 : hist[i];
   endfunction

   function automatic logic [15:0] mf_at(input int i);
      return (i <= 0) ? 16'h0 : mf[i];
   endfunction

   function automatic logic [31:0] model_read(input logic [19:0] off);
      logic [15:0] cur;
      cur = mf_at(t);
      if (off == 20'h00) return {24'h0, m_len};
      if (off == 20'h04) return {24'h0, m_ren};
      if (off == 20'h08) return {24'h0, m_fen};
      if (off == 20'h0C) return {16'h0, cur};
      if (off == 20'h10) return {24'h0, m_flags};
      if (off >= 20'h20 && off < 20'h40) return CNT_EN ? 32'(m_cnt[int'(off - 20'h20) / 4]) : 32'h0;
      return 32'h0;
   endfunction

   // Advance one clock, update the model from the inputs the DUT sampled, compare outputs.
   task automatic tick();
      logic [15:0] raw_now, prev, pp, nf, s, cur;
      logic        wen_now, ren_now, rst_now, still;
      logic [19:0] off_now;
      logic [31:0] wd_now, rd_now;
      logic [7:0]  rise_v, fall_v, ev, clr;
      int          run;
      raw_now = {exp_n_raw_i, exp_p_raw_i};
      wen_now = sys_wen;
      ren_now = sys_ren;
      rst_now = rst_i;
      off_now = sys_addr[19:0];
      wd_now  = sys_wdata;
      @(posedge clk);
      #1;
      if (rst_now) begin
         t = 0;
         m_len = 8'd4; m_ren = '0; m_fen = '0; m_flags = '0; m_trig = '0; m_ack = 1'b0; m_rd = '0;
         for (int i = 0; i < DWE; i++) m_cnt[i] = 0;
      end else begin
         rd_now = ren_now ? model_read(off_now) : 32'h0;
         prev = mf_at(t);
         pp   = mf_at(t - 1);
         t++;
         if (t > MAXC) begin
            $display("FAIL model_range: actual=%0d required<=%0d", t, MAXC);
            failures++;
            $fatal(1, "model history exhausted");
         end
         hist[t] = raw_now;
         for (int j = 0; j < 16; j++) begin
            run = 0;
            still = 1'b1;
            for (int k = 0; k <= int'(m_len); k++) begin
               if (still) begin
                  s = hist_at(t - SYNC - k);
                  if (s[j] != prev[j]) run++;
                  else still = 1'b0;
               end
            end
            nf[j] = (run == int'(m_len) + 1) ? ~prev[j] : prev[j];
         end
         mf[t] = nf;
         rise_v = prev[7:0] & ~pp[7:0];
         fall_v = ~prev[7:0] & pp[7:0];
         ev     = (rise_v & m_ren) | (fall_v & m_fen);
         clr    = (wen_now && off_now == 20'h10) ? wd_now[7:0] : 8'h0;
         m_flags = (m_flags & ~clr) | ev;
         for (int i = 0; i < DWE; i++) begin
            if (wen_now && off_now >= 20'h20 && off_now < 20'h40 && int'(off_now - 20'h20) / 4 == i)
               m_cnt[i] = int'(ev[i]);
            else if (ev[i])
               m_cnt[i] = (m_cnt[i] + 1) % CMOD;
         end
         if (wen_now && off_now == 20'h00) m_len = wd_now[7:0];
         if (wen_now && off_now == 20'h04) m_ren = wd_now[7:0];
         if (wen_now && off_now == 20'h08) m_fen = wd_now[7:0];
         m_trig = ev;
         m_ack  = wen_now | ren_now;
         m_rd   = rd_now;
      end
      cur = mf_at(t);
      check("tick_p_dat", 32'(exp_p_dat_o), 32'(cur[7:0]));
      check("tick_n_dat", 32'(exp_n_dat_o), 32'(cur[15:8]));
      check("tick_trig", 32'(exp_trig_o), 32'(m_trig));
      check("tick_ack", 32'(sys_ack), 32'(m_ack));
      check("tick_err", 32'(sys_err), 32'h0);
      if (ren_now && !rst_now) check("tick_rdata", sys_rdata, m_rd);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      sys_addr = addr; sys_wdata = data; sys_wen = 1'b1;
      tick();
      sys_wen = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      sys_addr = addr; sys_ren = 1'b1;
      tick();
      sys_ren = 1'b0;
      data = sys_rdata;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs [20];

   initial begin
      logic [31:0] rd;
      int          n_trig, saw_dat, saw_trig;

      vecs[0]  = '{0, 32'h0000_0000, 32'h0, 32'h4};
      vecs[1]  = '{0, 32'h0000_0004, 32'h0, 32'h0};
      vecs[2]  = '{0, 32'h0000_0008, 32'h0, 32'h0};
      vecs[3]  = '{0, 32'h0000_000C, 32'h0, 32'h0};
      vecs[4]  = '{0, 32'h0000_0010, 32'h0, 32'h0};
      vecs[5]  = '{1, 32'h0000_0004, 32'hA5, 32'h0};
      vecs[6]  = '{0, 32'h0000_0004, 32'h0, 32'hA5};
      vecs[7]  = '{1, 32'h0000_0008, 32'hFFFF_FF3C, 32'h0};
      vecs[8]  = '{0, 32'h0000_0008, 32'h0, 32'h3C};
      vecs[9]  = '{1, 32'h0000_0000, 32'h103, 32'h0};
      vecs[10] = '{0, 32'h0010_0000, 32'h0, 32'h3};
      vecs[11] = '{1, 32'h0000_000C, 32'hFFFF, 32'h0};
      vecs[12] = '{0, 32'h0000_000C, 32'h0, 32'h0};
      vecs[13] = '{0, 32'h0000_0014, 32'h0, 32'h0};
      vecs[14] = '{0, 32'h0000_0044, 32'h0, 32'h0};
      vecs[15] = '{0, 32'h0000_1000, 32'h0, 32'h0};
      vecs[16] = '{1, 32'h0000_0000, 32'h4, 32'h0};
      vecs[17] = '{1, 32'h0000_0004, 32'h0, 32'h0};
      vecs[18] = '{1, 32'h0000_0008, 32'h0, 32'h0};
      vecs[19] = '{0, 32'h0000_0000, 32'h0, 32'h4};

      for (int i = 0; i < DWE; i++) m_cnt[i] = 0;
      rst_i = 1'b1;
      ticks(3);
      rst_i = 1'b0;
      check("reset_p_dat", 32'(exp_p_dat_o), 32'h0);
      check("reset_trig", 32'(exp_trig_o), 32'h0);
      check("reset_ack", 32'(sys_ack), 32'h0);

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].data);
         end else begin
            bus_read(vecs[i].addr, rd);
            check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
         end
      end

      // Glitch as long as filt_len (4) must be swallowed.
      exp_p_raw_i[0] = 1'b1;
      saw_dat = 0; saw_trig = 0;
      for (int i = 0; i < 4; i++) begin tick(); saw_dat |= int'(exp_p_dat_o[0]); end
      exp_p_raw_i[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(); saw_dat |= int'(exp_p_dat_o[0]); saw_trig |= int'(exp_trig_o[0]);
      end
      check("glitch_dat0", 32'(saw_dat), 32'h0);
      check("glitch_trig0", 32'(saw_trig), 32'h0);

      // 20-cycle pulse: level follows 7 cycles after each raw edge.
      exp_p_raw_i[0] = 1'b1;
      ticks(6);
      check("rise_lat6", 32'(exp_p_dat_o[0]), 32'h0);
      tick();
      check("rise_lat7", 32'(exp_p_dat_o[0]), 32'h1);
      ticks(13);
      exp_p_raw_i[0] = 1'b0;
      ticks(6);
      check("fall_lat6", 32'(exp_p_dat_o[0]), 32'h1);
      tick();
      check("fall_lat7", 32'(exp_p_dat_o[0]), 32'h0);
      ticks(4);

      // Both edges enabled, filt_len=0: one pulse gives two trigger pulses.
      bus_write(32'h00, 32'h0);
      bus_write(32'h04, 32'h01);
      bus_write(32'h08, 32'h01);
      exp_p_raw_i[0] = 1'b1;
      n_trig = 0;
      for (int i = 0; i < 3; i++) begin tick(); n_trig += int'(exp_trig_o[0]); end
      exp_p_raw_i[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(); n_trig += int'(exp_trig_o[0]); end
      check("pulse_trig_count", 32'(n_trig), 32'h2);
      bus_read(32'h20, rd);
      check("pulse_cnt0", rd, CNT_EN ? 32'h2 : 32'h0);
      bus_read(32'h10, rd);
      check("pulse_flag0", rd, 32'h1);

      // W1C in the same cycle as a new edge: set wins.
      exp_p_raw_i[0] = 1'b1;
      ticks(3);
      bus_write(32'h10, 32'h01);
      bus_read(32'h10, rd);
      check("flag_set_wins", rd, 32'h1);
      bus_write(32'h10, 32'h01);
      bus_read(32'h10, rd);
      check("flag_cleared", rd, 32'h0);
      exp_p_raw_i[0] = 1'b0;
      ticks(6);

      // Counter wrap on pin 3 and clear-with-event.
      bus_write(32'h04, 32'h08);
      bus_write(32'h08, 32'h08);
      bus_write(32'h2C, 32'h0);
      for (int i = 0; i < CMOD - 1; i++) begin
         exp_p_raw_i[3] = ~exp_p_raw_i[3];
         ticks(3);
      end
      ticks(3);
      bus_read(32'h2C, rd);
      check("cnt3_full", rd, CNT_EN ? 32'(CMOD - 1) : 32'h0);
      exp_p_raw_i[3] = ~exp_p_raw_i[3];
      ticks(5);
      bus_read(32'h2C, rd);
      check("cnt3_wrap", rd, 32'h0);
      exp_p_raw_i[3] = ~exp_p_raw_i[3];
      ticks(3);
      bus_write(32'h2C, 32'h0);
      bus_read(32'h2C, rd);
      check("cnt3_clr_event", rd, CNT_EN ? 32'h1 : 32'h0);
      ticks(4);

      // Reset in the middle of a long p1 pulse, with a read in flight.
      bus_write(32'h00, 32'h2);
      bus_write(32'h04, 32'hFF);
      exp_p_raw_i[1] = 1'b1;
      ticks(10);
      rst_i = 1'b1; sys_ren = 1'b1; sys_addr = 32'h0;
      tick();
      rst_i = 1'b0; sys_ren = 1'b0;
      check("rst_p_dat", 32'(exp_p_dat_o), 32'h0);
      check("rst_n_dat", 32'(exp_n_dat_o), 32'h0);
      check("rst_trig", 32'(exp_trig_o), 32'h0);
      check("rst_ack", 32'(sys_ack), 32'h0);
      check("rst_rdata", sys_rdata, 32'h0);
      tick();
      check("rst_no_late_ack", 32'(sys_ack), 32'h0);
      bus_read(32'h00, rd);
      check("rst_filt_len", rd, 32'h4);
      bus_read(32'h20, rd);
      check("rst_cnt0", rd, 32'h0);
      ticks(20);
      exp_p_raw_i[1] = 1'b0;
      ticks(10);

      // Randomized segments checked against the model every cycle.
      for (int seg = 0; seg < 8; seg++) begin
         bus_write(32'h00, 32'($urandom_range(0, 6)));
         bus_write(32'h04, 32'($urandom_range(0, 255)));
         bus_write(32'h08, 32'($urandom_range(0, 255)));
         for (int c = 0; c < 150; c++) begin
            for (int b = 0; b < DWE; b++) begin
               if ($urandom_range(0, 5) == 0) exp_p_raw_i[b] = ~exp_p_raw_i[b];
               if ($urandom_range(0, 5) == 0) exp_n_raw_i[b] = ~exp_n_raw_i[b];
            end
            case ($urandom_range(0, 15))
               0:       bus_read(32'($urandom_range(0, 17)) * 4, rd);
               1:       bus_write(32'h10, 32'($urandom_range(0, 255)));
               2:       bus_write(32'h20 + 32'($urandom_range(0, 7)) * 4, 32'h0);
               default: tick();
            endcase
         end
         bus_read(32'h10, rd);
         for (int i = 0; i < DWE; i++) bus_read(32'h20 + 32'(i) * 4, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
